// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: load, run-control and controller handshake bundle for the instruction sequencer.
interface prog_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
);
    logic              Ld_we;
    logic [ADDR_W-1:0] Ld_addr;
    logic [DATA_W-1:0] Ld_data;
    logic              Run;
    logic              Step;
    logic              Rewind;
    logic              Ext;
    logic              Clr;
    logic [DATA_W-1:0] Data;
    logic [1:0]        T;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic              Done;
    logic              Err;
    modport slave (
        input  Ld_we, Ld_addr, Ld_data, Run, Step, Rewind, Ext, Clr,
        output Data, T, PC, Busy, Done, Err
    );
    modport master (
        output Ld_we, Ld_addr, Ld_data, Run, Step, Rewind, Ext, Clr,
        input  Data, T, PC, Busy, Done, Err
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: program memory, PC and timestep sequencing with run/step/halt control.
module prog_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
) (
    input logic              Clock,
    input logic              Resetn,
    prog_sequencer_if.slave  bus
);
    localparam logic [DATA_W-1:0] HALT_WORD = DATA_W'(1) << (DATA_W - 2);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t            state;
    logic              single_step;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur;
    assign cur      = mem[bus.PC];
    assign bus.Data = bus.Ext ? cur : '0;
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= HALT_WORD;
        end else if (bus.Ld_we && state != RUN) begin
            mem[bus.Ld_addr] <= bus.Ld_data;
        end
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            single_step <= 1'b0;
            bus.T       <= '0;
            bus.PC      <= '0;
            bus.Busy    <= 1'b0;
            bus.Done    <= 1'b0;
            bus.Err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.T <= '0;
                    if (bus.Rewind) begin
                        bus.PC   <= '0;
                        bus.Done <= 1'b0;
                        bus.Err  <= 1'b0;
                    end else if (bus.Run || bus.Step) begin
                        state       <= RUN;
                        single_step <= !bus.Run;
                        bus.Busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.T == 2'd0) begin
                        // halt words are recognised at fetch, before the controller sees them
                        if (cur[DATA_W-1 -: 2] == 2'b01) begin
                            state    <= HALT;
                            bus.Done <= 1'b1;
                            bus.Busy <= 1'b0;
                        end else begin
                            bus.T <= 2'd1;
                        end
                    end else if (bus.Clr) begin
                        bus.T  <= '0;
                        bus.PC <= bus.PC + ADDR_W'(1);
                        if (single_step || !bus.Run) begin
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
                        end
                    end else if (bus.T == 2'd3) begin
                        state    <= HALT;
                        bus.Err  <= 1'b1;
                        bus.T    <= '0;
                        bus.Busy <= 1'b0;
                    end else begin
                        bus.T <= bus.T + 2'd1;
                    end
                end
                HALT: begin
                    bus.T <= '0;
                    if (bus.Rewind) begin
                        state    <= IDLE;
                        bus.PC   <= '0;
                        bus.Done <= 1'b0;
                        bus.Err  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: randomized run/step/halt stimulus checked against a spec-level reference model.
module tb_prog_sequencer;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    int m_state, m_t, m_pc;
    bit m_done, m_err, m_ss, did_rst;
    logic [9:0] m_mem [16];
    prog_sequencer_if #(.ADDR_W(4), .DATA_W(10)) bus ();
    prog_sequencer #(.DEPTH(16), .ADDR_W(4), .DATA_W(10)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus.slave)
    );
    always #5 Clock = ~Clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic drive(input bit run, input bit step, input bit rew, input bit we,
                         input logic [3:0] addr, input logic [9:0] data, input bit ext, input bit clr);
        bus.Run = run; bus.Step = step; bus.Rewind = rew; bus.Ld_we = we;
        bus.Ld_addr = addr; bus.Ld_data = data; bus.Ext = ext; bus.Clr = clr;
    endtask
    task automatic model_reset();
        m_state = S_IDLE; m_t = 0; m_pc = 0; m_done = 0; m_err = 0; m_ss = 0;
        foreach (m_mem[i]) m_mem[i] = 10'h100;
    endtask
    task automatic check_all();
        chk("T", 32'(bus.T), 32'(m_t));
        chk("PC", 32'(bus.PC), 32'(m_pc));
        chk("Busy", 32'(bus.Busy), 32'(m_state == S_RUN));
        chk("Done", 32'(bus.Done), 32'(m_done));
        chk("Err", 32'(bus.Err), 32'(m_err));
        chk("Data", 32'(bus.Data), bus.Ext ? 32'(m_mem[m_pc]) : 32'd0);
    endtask
    task automatic model_step();
        int prev = m_state;
        case (m_state)
            S_IDLE:
                if (bus.Rewind) begin m_pc = 0; m_done = 0; m_err = 0; end
                else if (bus.Run) begin m_state = S_RUN; m_ss = 0; end
                else if (bus.Step) begin m_state = S_RUN; m_ss = 1; end
            S_RUN:
                if (m_t == 0) begin
                    if (m_mem[m_pc][9:8] == 2'b01) begin m_state = S_HALT; m_done = 1; end
                    else m_t = 1;
                end else if (bus.Clr) begin
                    m_t = 0;
                    m_pc = (m_pc + 1) % 16;
                    if (m_ss || !bus.Run) m_state = S_IDLE;
                end else if (m_t < 3) m_t++;
                else begin m_state = S_HALT; m_err = 1; m_t = 0; end
            default:
                if (bus.Rewind) begin m_state = S_IDLE; m_pc = 0; m_done = 0; m_err = 0; end
        endcase
        if (bus.Ld_we && prev != S_RUN) m_mem[bus.Ld_addr] = bus.Ld_data;
    endtask
    task automatic tick();
        #1 check_all();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask
    task automatic rand_inputs();
        logic [9:0] d = 10'($urandom);
        bit run = bus.Run;
        if ($urandom_range(15) == 0) run = !run;
        if (d[9:8] == 2'b01 && $urandom_range(7) != 0) d[9:8] = 2'b00;
        drive(run, $urandom_range(9) == 0, $urandom_range(11) == 0, $urandom_range(2) == 0,
              4'($urandom), d, $urandom_range(3) != 0, $urandom_range(2) == 0);
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("halt_done", 32'(bus.Done), 32'd1);
        chk("halt_pc", 32'(bus.PC), 32'd0);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 4'd0, 10'h000, 1, 0); tick();
        drive(0, 0, 0, 1, 4'd1, 10'h012, 1, 0); tick();
        drive(0, 0, 0, 1, 4'd2, 10'h100, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && m_state != S_HALT; i++) begin
            bus.Clr = (m_pc == 0 && m_t == 1) || (m_pc == 1 && m_t == 3);
            tick();
        end
        chk("prog_done", 32'(m_done && m_pc == 2), 32'd1);
        did_rst = 0;
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            if (i >= 2000 && !did_rst && m_state == S_RUN && m_t == 2) begin
                did_rst = 1;
                bus.Ext = 1'b1;
                #2 Resetn = 1'b0;
                #1 model_reset();
                check_all();
                chk("rst_data", 32'(bus.Data), 32'h100);
                #1 Resetn = 1'b1;
                bus.Run = 1'b0;
            end
            tick();
        end
        chk("reset_injected", 32'(did_rst), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
